// File: rtl/discr_scaler_counter_8b.sv
// Windowed scaler for the 8-bit-parallel discriminator stream.
// Counts rising edges that the inhibit mask does not block, over back-to-back
// gate windows of i_period_len cycles. At each window end it publishes the
// saturating total, a saturation flag and a wrapping sequence number, together
// with a one-cycle valid strobe.
module discr_scaler_counter_8b #(
  parameter int P_PERIOD_WIDTH = 32,
  parameter int P_CNT_WIDTH    = 24,
  parameter int P_IDX_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                bits_in,
  input  logic [7:0]                inhibit_bits,
  input  logic [P_PERIOD_WIDTH-1:0] period_len,
  output logic [P_CNT_WIDTH-1:0]    scaler_out,
  output logic                      scaler_sat,
  output logic [P_IDX_WIDTH-1:0]    scaler_idx,
  output logic                      scaler_valid
);

  localparam int SUM_WIDTH = P_CNT_WIDTH + 1;
  localparam logic [P_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [P_PERIOD_WIDTH-1:0] i_period_len;
  logic [P_PERIOD_WIDTH-1:0] wcnt;
  logic                      prev_last_bit;
  logic [7:0]                edges;
  logic [7:0]                qual_r;
  logic [3:0]                n;
  logic [P_CNT_WIDTH-1:0]    acc;
  logic                      win_sat;
  logic [SUM_WIDTH-1:0]      sum;
  logic                      clamp;
  logic [P_CNT_WIDTH-1:0]    sum_sat;
  logic                      window_end;

  // Rising edges within the word; bit 0 looks back at the last bit of the previous word.
  always_comb begin
    edges      = '0;
    edges[0]   = bits_in[0] & ~prev_last_bit;
    edges[7:1] = bits_in[7:1] & ~bits_in[6:0];
  end

  // Stage 1: register the window length and the qualified edges; the last bit is kept even when inhibited.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_period_len  <= '0;
      prev_last_bit <= 1'b0;
      qual_r        <= '0;
    end else begin
      i_period_len  <= period_len;
      prev_last_bit <= bits_in[7];
      qual_r        <= edges & ~inhibit_bits;
    end
  end

  // Stage 2 arithmetic: edge count of the word, saturating add, and window-end detection.
  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(qual_r[i]);
    end
    sum        = {1'b0, acc} + SUM_WIDTH'(n);
    clamp      = sum[P_CNT_WIDTH];
    sum_sat    = clamp ? CNT_MAX : sum[P_CNT_WIDTH-1:0];
    window_end = (i_period_len != '0) &&
                 (wcnt >= (i_period_len - P_PERIOD_WIDTH'(1)));
  end

  // Stage 2 state: accumulate within a window, publish and restart at the window end, idle when length is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      wcnt         <= '0;
      win_sat      <= 1'b0;
      scaler_out   <= '0;
      scaler_sat   <= 1'b0;
      scaler_idx   <= '0;
      scaler_valid <= 1'b0;
    end else if (i_period_len == '0) begin
      acc          <= '0;
      wcnt         <= '0;
      win_sat      <= 1'b0;
      scaler_valid <= 1'b0;
    end else if (window_end) begin
      scaler_out   <= sum_sat;
      scaler_sat   <= win_sat | clamp;
      scaler_idx   <= scaler_idx + P_IDX_WIDTH'(1);
      scaler_valid <= 1'b1;
      acc          <= '0;
      wcnt         <= '0;
      win_sat      <= 1'b0;
    end else begin
      scaler_valid <= 1'b0;
      wcnt         <= wcnt + P_PERIOD_WIDTH'(1);
      acc          <= sum_sat;
      win_sat      <= win_sat | clamp;
    end
  end

endmodule

// File: tb/tb_discr_scaler_counter_8b.sv
// Self-checking bench for discr_scaler_counter_8b.
// A narrow counter (4 bits) and a narrow index (4 bits) make saturation and
// index wrap reachable in a short run.
module tb_discr_scaler_counter_8b;

  localparam int PW      = 32;
  localparam int CW      = 4;
  localparam int IW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    bits_in;
  logic [7:0]    inhibit_bits;
  logic [PW-1:0] period_len;
  logic [CW-1:0] scaler_out;
  logic          scaler_sat;
  logic [IW-1:0] scaler_idx;
  logic          scaler_valid;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    int out;
    int sat;
    int idx;
  } strobe_t;

  strobe_t strobes[$];

  // Behavioural model state: the stream is seen as a serial bit sequence.
  bit     model_live = 1'b0;
  int     m_prev_bit;
  int     pend_n;
  longint pend_len;
  longint m_pos;
  int     m_total;
  int     m_out, m_sat, m_idx, m_valid;

  always #5 clk = ~clk;

  discr_scaler_counter_8b #(
    .P_PERIOD_WIDTH(PW),
    .P_CNT_WIDTH   (CW),
    .P_IDX_WIDTH   (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bits_in     (bits_in),
    .inhibit_bits(inhibit_bits),
    .period_len  (period_len),
    .scaler_out  (scaler_out),
    .scaler_sat  (scaler_sat),
    .scaler_idx  (scaler_idx),
    .scaler_valid(scaler_valid)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] inh,
                               input logic [PW-1:0] plen, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      bits_in      = b;
      inhibit_bits = inh;
      period_len   = plen;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic resetDut(input logic [PW-1:0] plen);
    rst = 1'b1;
    applyStimulus(8'h00, 8'h00, plen, 2);
    rst = 1'b0;
    strobes.delete();
  endtask

  task automatic checkStrobe(input string name, input int k, input int out,
                             input int sat, input int idx);
    if (strobes.size() <= k) begin
      checkOutput({name, "_present"}, strobes.size(), k + 1);
    end else begin
      checkOutput({name, "_out"}, strobes[k].out, out);
      checkOutput({name, "_sat"}, strobes[k].sat, sat);
      checkOutput({name, "_idx"}, strobes[k].idx, idx);
    end
  endtask

  // Model: the total of a window is every 0->1 transition in time order not masked by inhibit.
  always @(posedge clk) begin
    int cnt;
    int last;
    if (rst) begin
      m_prev_bit = 0;
      pend_n     = 0;
      pend_len   = 0;
      m_pos      = 0;
      m_total    = 0;
      m_out      = 0;
      m_sat      = 0;
      m_idx      = 0;
      m_valid    = 0;
    end else begin
      if (pend_len == 0) begin
        m_pos   = 0;
        m_total = 0;
        m_valid = 0;
      end else begin
        m_total += pend_n;
        if (m_pos >= pend_len - 1) begin
          m_out   = (m_total > CNT_MAX) ? CNT_MAX : m_total;
          m_sat   = (m_total > CNT_MAX) ? 1 : 0;
          m_idx   = (m_idx + 1) % (1 << IW);
          m_valid = 1;
          m_total = 0;
          m_pos   = 0;
        end else begin
          m_valid = 0;
          m_pos++;
        end
      end
      cnt  = 0;
      last = m_prev_bit;
      for (int i = 0; i < 8; i++) begin
        if (bits_in[i] && last == 0 && !inhibit_bits[i]) cnt++;
        last = bits_in[i];
      end
      m_prev_bit = bits_in[7];
      pend_n     = cnt;
      pend_len   = longint'(period_len);
    end
    model_live = 1'b1;
  end

  // Every cycle: DUT outputs against the model, and record each strobe.
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("valid", scaler_valid, m_valid);
      checkOutput("out", scaler_out, m_out);
      checkOutput("sat", scaler_sat, m_sat);
      checkOutput("idx", scaler_idx, m_idx);
      if (scaler_valid) strobes.push_back('{int'(scaler_out), int'(scaler_sat), int'(scaler_idx)});
    end
  end

  initial begin
    int found_step;
    int last_step;
    int n_gaps;
    rst          = 1'b1;
    bits_in      = 8'h00;
    inhibit_bits = 8'h00;
    period_len   = '0;

    // Reset state
    resetDut(10);
    checkOutput("reset_out", scaler_out, 0);
    checkOutput("reset_idx", scaler_idx, 0);
    checkOutput("reset_valid", scaler_valid, 0);

    // Single edge, then an empty window
    applyStimulus(8'h01, 8'h00, 10, 1);
    applyStimulus(8'h00, 8'h00, 10, 20);
    checkOutput("single_count", strobes.size(), 2);
    checkStrobe("single_w1", 0, 1, 0, 1);
    checkStrobe("single_w2", 1, 0, 0, 2);

    // Multi-edge word, cross-word non-edge, held-high word
    resetDut(10);
    applyStimulus(8'h55, 8'h00, 10, 1);
    applyStimulus(8'h00, 8'h00, 10, 9);
    applyStimulus(8'h80, 8'h00, 10, 1);
    applyStimulus(8'h01, 8'h00, 10, 1);
    applyStimulus(8'h00, 8'h00, 10, 8);
    applyStimulus(8'hff, 8'h00, 10, 5);
    applyStimulus(8'h00, 8'h00, 10, 6);
    checkOutput("multi_count", strobes.size(), 3);
    checkStrobe("multi_55", 0, 4, 0, 1);
    checkStrobe("multi_cross", 1, 1, 0, 2);
    checkStrobe("multi_ff", 2, 1, 0, 3);

    // Inhibit masking
    resetDut(10);
    applyStimulus(8'h55, 8'hfe, 10, 1);
    applyStimulus(8'h00, 8'h00, 10, 9);
    applyStimulus(8'h55, 8'hff, 10, 1);
    applyStimulus(8'h00, 8'h00, 10, 10);
    checkStrobe("inhibit_fe", 0, 1, 0, 1);
    checkStrobe("inhibit_ff", 1, 0, 0, 2);

    // Saturation, then a clean window
    resetDut(20);
    applyStimulus(8'h55, 8'h00, 20, 20);
    applyStimulus(8'h00, 8'h00, 20, 21);
    checkStrobe("sat_full", 0, 15, 1, 1);
    checkStrobe("sat_clear", 1, 0, 0, 2);

    // Length 1: a strobe every cycle, index wraps at 16
    resetDut(1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus((k % 2 == 0) ? 8'h01 : 8'h00, 8'h00, 1, 1);
      if (k >= 1) begin
        checkOutput("len1_valid", scaler_valid, 1);
        checkOutput("len1_out", scaler_out, ((k - 1) % 2 == 0) ? 1 : 0);
        checkOutput("len1_idx", scaler_idx, k % 16);
      end
    end

    // Length 0: no strobes, outputs hold
    applyStimulus(8'h01, 8'h00, 0, 2);
    strobes.delete();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(8'h01, 8'h00, 0, 1);
      applyStimulus(8'h00, 8'h00, 0, 1);
    end
    checkOutput("len0_strobes", strobes.size(), 0);
    checkOutput("len0_idx_hold", scaler_idx, 4);

    // Reset mid-window
    resetDut(5);
    applyStimulus(8'h00, 8'h00, 5, 11);
    checkOutput("pre_rst_idx", scaler_idx, 2);
    strobes.delete();
    applyStimulus(8'h01, 8'h00, 100, 1);
    applyStimulus(8'h00, 8'h00, 100, 4);
    rst = 1'b1;
    applyStimulus(8'h00, 8'h00, 100, 2);
    rst = 1'b0;
    checkOutput("rst_idx", scaler_idx, 0);
    checkOutput("rst_no_strobe", strobes.size(), 0);
    applyStimulus(8'h00, 8'h00, 100, 20);
    checkOutput("post_rst_no_strobe", strobes.size(), 0);

    // Shrink from 100 to 3 mid-window
    resetDut(100);
    applyStimulus(8'h01, 8'h00, 100, 1);
    applyStimulus(8'h00, 8'h00, 100, 50);
    found_step = 0;
    for (int s = 1; s <= 6 && found_step == 0; s++) begin
      applyStimulus(8'h00, 8'h00, 3, 1);
      if (scaler_valid) found_step = s;
    end
    checkOutput("shrink_latency", found_step, 2);
    checkStrobe("shrink_first", 0, 1, 0, 1);
    last_step = 0;
    n_gaps    = 0;
    for (int s = 1; s <= 9; s++) begin
      applyStimulus(8'h00, 8'h00, 3, 1);
      if (scaler_valid) begin
        checkOutput("shrink_gap", s - last_step, 3);
        last_step = s;
        n_gaps++;
      end
    end
    checkOutput("shrink_strobes", n_gaps, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
